// File: rtl/pipe_stage_reg.sv
// Elastic pipeline stage register: valid/ready handshake with a 2-entry skid buffer,
// synchronous flush and bubble insertion on the control bundle.
module pipe_stage_reg #(
    parameter int unsigned        DATA_W      = 71,
    parameter int unsigned        CTRL_W      = 3,
    parameter logic [CTRL_W-1:0]  CTRL_BUBBLE = {CTRL_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy,
    output logic [15:0]       stall_cnt
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both 1.
    // in_ready is a register (~skid_v) and never depends on out_ready in the same cycle.

    // State encoding equals the number of held entries, so it doubles as occupancy.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state;
    logic              ready_q;
    logic [DATA_W-1:0] main_d;
    logic [CTRL_W-1:0] main_c;
    logic [DATA_W-1:0] skid_d;
    logic [CTRL_W-1:0] skid_c;
    logic              main_v;
    logic              skid_v;
    logic              accept;
    logic              consume;

    assign main_v  = (state != EMPTY);
    assign skid_v  = (state == FULL);
    assign accept  = in_valid & ready_q;
    assign consume = main_v & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            ready_q   <= 1'b1;
            main_d    <= '0;
            main_c    <= CTRL_BUBBLE;
            skid_d    <= '0;
            skid_c    <= CTRL_BUBBLE;
            stall_cnt <= '0;
        end else begin
            // Stall counter survives flush; only reset clears it.
            if (main_v && !out_ready && stall_cnt != 16'hFFFF) begin
                stall_cnt <= stall_cnt + 16'd1;
            end

            if (flush) begin
                state   <= EMPTY;
                ready_q <= 1'b1;
            end else begin
                case (state)
                    EMPTY: begin
                        if (accept) begin
                            main_d <= in_data;
                            main_c <= in_ctrl;
                            state  <= ONE;
                        end
                    end
                    ONE: begin
                        if (accept && consume) begin
                            main_d <= in_data;
                            main_c <= in_ctrl;
                        end else if (consume) begin
                            state <= EMPTY;
                        end else if (accept) begin
                            skid_d  <= in_data;
                            skid_c  <= in_ctrl;
                            ready_q <= 1'b0;
                            state   <= FULL;
                        end
                    end
                    FULL: begin
                        if (consume) begin
                            main_d  <= skid_d;
                            main_c  <= skid_c;
                            ready_q <= 1'b1;
                            state   <= ONE;
                        end
                    end
                    default: begin
                        state   <= EMPTY;
                        ready_q <= 1'b1;
                    end
                endcase
            end
        end
    end

    // Data stays stale on bubbles; only the control bundle is forced to a NOP.
    assign in_ready  = ready_q;
    assign out_valid = main_v;
    assign out_data  = main_d;
    assign out_ctrl  = main_v ? main_c : CTRL_BUBBLE;
    assign occupancy = state;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: FIFO-queue reference model compared every
// negedge, plus directed scenarios with literal expectations.
module tb_pipe_stage_reg;

    localparam int unsigned DATA_W = 71;
    localparam int unsigned CTRL_W = 3;
    localparam int unsigned ENT_W  = DATA_W + CTRL_W;

    logic              clk;
    logic              rst_n;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
    logic [1:0]        occupancy;
    logic [15:0]       stall_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    pipe_stage_reg #(
        .DATA_W      (DATA_W),
        .CTRL_W      (CTRL_W),
        .CTRL_BUBBLE (3'b000)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl),
        .occupancy (occupancy),
        .stall_cnt (stall_cnt)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: held entries as a FIFO queue of {ctrl, data}
    logic [ENT_W-1:0] exp_q[$];
    logic             m_ready = 1'b1;
    logic [15:0]      m_cnt   = 16'd0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            m_ready <= 1'b1;
            m_cnt   <= 16'd0;
        end else begin
            bit acc;
            bit con;
            acc = in_valid && m_ready;
            con = (exp_q.size() > 0) && out_ready;
            if (exp_q.size() > 0 && !out_ready && m_cnt != 16'hFFFF) m_cnt <= m_cnt + 16'd1;
            if (flush) begin
                exp_q.delete();
            end else begin
                if (con) void'(exp_q.pop_front());
                if (acc) exp_q.push_back({in_ctrl, in_data});
            end
            m_ready <= (exp_q.size() < 2);
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp_v);
        n_checks++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp_v, $time);
    endtask

    // Compare process
    always @(negedge clk) begin
        logic [ENT_W-1:0] head;
        bit nonempty;
        nonempty = exp_q.size() > 0;
        head = nonempty ? exp_q[0] : '0;
        check("m_out_valid", 128'(out_valid), 128'(nonempty));
        check("m_out_ctrl", 128'(out_ctrl), nonempty ? 128'(head[ENT_W-1:DATA_W]) : 128'(0));
        if (nonempty) check("m_out_data", 128'(out_data), 128'(head[DATA_W-1:0]));
        check("m_in_ready", 128'(in_ready), 128'(m_ready));
        check("m_occupancy", 128'(occupancy), 128'(exp_q.size()));
        check("m_stall_cnt", 128'(stall_cnt), 128'(m_cnt));
    end

    // Driver: present inputs, then let one rising edge pass
    task automatic step(input logic v, input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c,
                        input logic ordy, input logic fl);
        in_valid  = v;
        in_data   = d;
        in_ctrl   = c;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 71'h5A;
        in_ctrl   = 3'b111;
        out_ready = 1'b1;

        // Reset with an offered entry
        repeat (3) step(1'b1, 71'h5A, 3'b111, 1'b1, 1'b0);
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_out_ctrl", 128'(out_ctrl), 128'(0));
        check("rst_out_data", 128'(out_data), 128'(0));
        check("rst_in_ready", 128'(in_ready), 128'(1));
        check("rst_occupancy", 128'(occupancy), 128'(0));
        rst_n = 1'b1;
        step(1'b1, 71'h5A, 3'b111, 1'b1, 1'b0);
        check("first_valid", 128'(out_valid), 128'(1));
        check("first_ctrl", 128'(out_ctrl), 128'(7));
        check("first_data", 128'(out_data), 128'(71'h5A));
        step(1'b0, '0, '0, 1'b1, 1'b0);

        // Streaming 1..8 at full rate
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, DATA_W'(i), CTRL_W'(i), 1'b1, 1'b0);
            check("stream_data", 128'(out_data), 128'(i));
            check("stream_occ", 128'(occupancy), 128'(1));
        end
        step(1'b0, '0, '0, 1'b1, 1'b0);
        check("stream_empty", 128'(out_valid), 128'(0));
        check("stream_stall", 128'(stall_cnt), 128'(0));

        // Backpressure: 1 passes, 2 stalls in main, 3 in skid, 4 held upstream
        step(1'b1, 71'd1, 3'd1, 1'b1, 1'b0);
        step(1'b1, 71'd2, 3'd2, 1'b1, 1'b0);
        check("bp_head2", 128'(out_data), 128'(2));
        step(1'b1, 71'd3, 3'd3, 1'b0, 1'b0);
        check("bp_full_occ", 128'(occupancy), 128'(2));
        check("bp_full_rdy", 128'(in_ready), 128'(0));
        repeat (4) step(1'b1, 71'd4, 3'd4, 1'b0, 1'b0);
        check("bp_hold_head", 128'(out_data), 128'(2));
        check("bp_hold_occ", 128'(occupancy), 128'(2));
        step(1'b1, 71'd4, 3'd4, 1'b1, 1'b0);
        check("bp_out3", 128'(out_data), 128'(3));
        check("bp_rdy_back", 128'(in_ready), 128'(1));
        check("bp_stall5", 128'(stall_cnt), 128'(5));
        step(1'b1, 71'd4, 3'd4, 1'b1, 1'b0);
        check("bp_out4", 128'(out_data), 128'(4));
        check("bp_ctrl4", 128'(out_ctrl), 128'(4));
        step(1'b0, '0, '0, 1'b1, 1'b0);
        check("bp_drained", 128'(occupancy), 128'(0));

        // Flush in FULL with a simultaneous offer
        step(1'b1, 71'h21, 3'd1, 1'b0, 1'b0);
        step(1'b1, 71'h22, 3'd2, 1'b0, 1'b0);
        check("fl_full", 128'(occupancy), 128'(2));
        step(1'b1, 71'h99, 3'd5, 1'b0, 1'b1);
        check("fl_valid", 128'(out_valid), 128'(0));
        check("fl_ctrl", 128'(out_ctrl), 128'(0));
        check("fl_occ", 128'(occupancy), 128'(0));
        check("fl_rdy", 128'(in_ready), 128'(1));
        check("fl_stall", 128'(stall_cnt), 128'(7));
        step(1'b0, '0, '0, 1'b1, 1'b0);
        check("fl_no_99", 128'(out_valid), 128'(0));

        // Stall counter saturation
        step(1'b1, 71'h33, 3'd3, 1'b0, 1'b0);
        in_valid = 1'b0;
        repeat (70000) @(posedge clk);
        #1;
        check("sat_ffff", 128'(stall_cnt), 128'(16'hFFFF));
        step(1'b0, '0, '0, 1'b0, 1'b0);
        check("sat_nowrap", 128'(stall_cnt), 128'(16'hFFFF));

        // Asynchronous reset pulse while FULL
        step(1'b1, 71'h44, 3'd4, 1'b0, 1'b0);
        check("ar_full", 128'(occupancy), 128'(2));
        in_valid = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        check("ar_valid", 128'(out_valid), 128'(0));
        check("ar_ctrl", 128'(out_ctrl), 128'(0));
        check("ar_occ", 128'(occupancy), 128'(0));
        check("ar_rdy", 128'(in_ready), 128'(1));
        check("ar_stall", 128'(stall_cnt), 128'(0));
        #4;
        rst_n = 1'b1;
        step(1'b1, 71'h11, 3'd3, 1'b1, 1'b0);
        check("ar_new_valid", 128'(out_valid), 128'(1));
        check("ar_new_data", 128'(out_data), 128'(71'h11));
        check("ar_new_ctrl", 128'(out_ctrl), 128'(3));
        step(1'b0, '0, '0, 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised, elastic pipeline stage register for the MIPS pipeline. It is the generic successor of the fixed EX/MEM latch and carries a DATA_W payload plus a CTRL_W control bundle (RegWrite, MemtoReg, MemWrite, ...) between any two stages. It adds a valid/ready handshake with a 2-entry skid buffer, synchronous flush, and bubble insertion. Every output has a defined reset value. Instances sit at IF/ID, ID/EX, EX/MEM and MEM/WB.

## Interface
Parameters:
- DATA_W, 71 — payload width (e.g. ALUOut 32 + WriteData 32 + WriteReg 5 + Zero 1 + spare 1).
- CTRL_W, 3 — control bundle width.
- CTRL_BUBBLE, {CTRL_W{1'b0}} — control value presented whenever no valid entry is at the output (a NOP).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous kill of all held entries (branch mispredict or exception).
- in_valid  in  1  upstream entry is present.
- in_ready  out  1  stage can accept an entry this cycle; driven from a register.
- in_data  in  DATA_W  upstream payload.
- in_ctrl  in  CTRL_W  upstream control bundle.
- out_valid  out  1  output entry is valid.
- out_ready  in  1  downstream consumes the output entry this cycle.
- out_data  out  DATA_W  payload of the head entry.
- out_ctrl  out  CTRL_W  control of the head entry; equals CTRL_BUBBLE when out_valid=0.
- occupancy  out  2  number of held entries (0..2).
- stall_cnt  out  16  saturating count of cycles with out_valid=1 and out_ready=0.

## Operation
- Storage:
  - main register (the head entry): main_v, main_d, main_c.
  - skid register: skid_v, skid_d, skid_c.
- Accept condition: in_valid & in_ready. Consume condition: out_valid & out_ready.
- out_valid=main_v, out_data=main_d, out_ctrl = main_v ? main_c : CTRL_BUBBLE.
- in_ready = ~skid_v, registered. It never depends combinationally on out_ready.
- States are named by occupancy:
  - EMPTY: main_v=0, skid_v=0.
  - ONE: main_v=1, skid_v=0.
  - FULL: main_v=1, skid_v=1.
- Transitions when flush=0:
  - EMPTY + accept -> ONE; the entry is loaded into main.
  - ONE + accept + consume -> ONE; main is replaced by the new entry.
  - ONE + consume, no accept -> EMPTY.
  - ONE + accept, no consume -> FULL; the entry is loaded into skid.
  - FULL + consume -> ONE; main takes skid, skid_v is cleared. No accept is possible in FULL because in_ready=0.
  - Any other combination holds the current state.
- Ordering is strictly FIFO; the skid entry is never presented ahead of main.
- flush=1 has priority over every other input:
  - next state is EMPTY, main_v=0, skid_v=0;
  - an input offered in the same cycle is dropped, even if in_ready=1;
  - a consume in the same cycle still counts as a completed transfer downstream.
- Data registers are not cleared on a bubble or flush; they keep their stale values. Consumers must qualify data with out_valid or out_ctrl.
- stall_cnt:
  - increments when out_valid & ~out_ready;
  - saturates at 16'hFFFF;
  - is not cleared by flush, only by reset.
- Reset values:
  - main_v=0, skid_v=0, in_ready=1, out_valid=0;
  - out_ctrl=CTRL_BUBBLE, out_data=0, skid_d=0;
  - occupancy=0, stall_cnt=0.

## Timing
- Latency is 1 cycle: an entry accepted at edge N is on the outputs, with out_valid=1, after edge N.
- Throughput is 1 entry per cycle while out_ready=1 continuously. The skid register stays empty in that case.
- in_ready drops one edge after the first cycle in which out_ready=0 and an accept both occur. Exactly one extra entry is absorbed into skid; none are lost.
- in_ready rises on the edge following the consume that drains skid.
- flush asserted in cycle N: after edge N, out_valid=0, in_ready=1, occupancy=0.
- Reset asserted mid-operation: all state clears immediately (asynchronously). Held entries are discarded without any handshake.

## Test plan
- Reset: drive in_valid=1, in_data=0x5A, in_ctrl=3'b111 while rst_n=0 -> out_valid=0, out_ctrl=000, out_data=0, in_ready=1, occupancy=0. After release, the first accept appears one cycle later with out_ctrl=111.
- Streaming: feed 8 entries data=1..8 back-to-back with out_ready=1 -> outputs appear 1..8 in consecutive cycles, occupancy never exceeds 1, stall_cnt=0.
- Backpressure: stream 1..4, hold out_ready=0 from the cycle entry 2 is accepted -> skid holds 3, in_ready=0, occupancy=2, entry 4 is held upstream. Release out_ready -> output order is 2,3,4 and stall_cnt equals the number of stalled cycles.
- Flush in FULL: in FULL, assert flush with in_valid=1 and data=0x99 -> next cycle out_valid=0, out_ctrl=CTRL_BUBBLE, occupancy=0; 0x99 never appears at the output.
- Stall counter: hold out_valid=1 and out_ready=0 for 70000 cycles -> stall_cnt=16'hFFFF and does not wrap.
- Async reset mid-stream: pulse rst_n low for half a cycle while in FULL -> outputs clear immediately with no clock edge required. After release, a new entry 0x11 is accepted with 1-cycle latency.
